// File: rtl/spawn_pkg.sv
// Shared types and constants for the obstacle spawner: object kinds, FSM states,
// the lane/kind request word and the lane wrap helper.
package spawn_pkg;

    localparam int NUM_LANES = 3;
    localparam int CD_W      = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        COIN = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        PICK,
        OFFER
    } state_t;

    typedef struct packed {
        logic [1:0] lane;
        kind_t      kind;
    } spawn_t;

    function automatic logic [1:0] next_lane(input logic [1:0] lane);
        return (lane >= 2'(NUM_LANES - 1)) ? 2'd0 : lane + 2'd1;
    endfunction

endpackage

// File: rtl/spawn_gap_timer.sv
// Frame-based cooldown counter: loads a gap in frames and flags the tick that
// ends it. frame_tick is expected to be gated by the caller to the counting phase.
module spawn_gap_timer
    import spawn_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [CD_W-1:0] value,
    input  logic            frame_tick,
    output logic            expire
);

    logic [CD_W-1:0] cooldown;

    // A loaded value of 0 behaves like 1 so the counter can never wrap.
    assign expire = frame_tick && (cooldown <= CD_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cooldown <= '0;
        end else if (load) begin
            cooldown <= value;
        end else if (frame_tick && !expire) begin
            cooldown <= cooldown - CD_W'(1);
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Turns the free-running random word into timed lane/kind spawn requests offered
// over valid/ready. Optional coin trails are enabled by defining COIN_TRAIL_EN.
module obstacle_spawner
    import spawn_pkg::*;
#(
    parameter int MIN_GAP        = 20,
    parameter int GAP_RANGE_BITS = 5,
    parameter int COIN_THRESH    = 4,
    parameter int TRAIL_LEN      = 3,
    parameter int TRAIL_GAP      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        run,
    input  logic [15:0] rnd,
    output logic        spawn_valid,
    input  logic        spawn_ready,
    output logic [1:0]  spawn_lane,
    output logic [1:0]  spawn_kind,
    output logic [15:0] spawn_count
);

    state_t          state_q, state_d;
    spawn_t          spawn_q, pick;
    logic [1:0]      last_lane_q;
    logic [15:0]     count_q;
    logic            handshake, cd_load, pick_en, expire, tick_en;
    logic [CD_W-1:0] gap_base, gap_value;
    logic            unused_rnd;

    function automatic spawn_t pick_from_rnd(input logic [15:0] r, input logic [1:0] prev);
        spawn_t s;
        s.lane = (r[1:0] != 2'd3) ? r[1:0] : next_lane(prev);
        if (int'(r[7:4]) < COIN_THRESH) begin
            s.kind = COIN;
        end else if (r[8]) begin
            s.kind = HIGH;
        end else begin
            s.kind = LOW;
        end
        return s;
    endfunction

    assign unused_rnd  = ^rnd;
    assign spawn_valid = (state_q == OFFER);
    assign handshake   = spawn_valid && spawn_ready;
    assign tick_en     = frame_tick && (state_q == COUNT);
    assign gap_base    = CD_W'(MIN_GAP) + CD_W'(rnd[GAP_RANGE_BITS-1:0]);

`ifdef COIN_TRAIL_EN
    logic [7:0] trail_q, trail_d;

    // Only a freely picked coin starts a trail; trail coins just count it down.
    always_comb begin
        trail_d = trail_q;
        if (!run) begin
            trail_d = '0;
        end else if (handshake) begin
            if (trail_q != '0) begin
                trail_d = trail_q - 8'd1;
            end else if (spawn_q.kind == COIN) begin
                trail_d = 8'(TRAIL_LEN);
            end
        end
    end

    assign gap_value = (trail_d != '0) ? CD_W'(TRAIL_GAP) : gap_base;

    always_comb begin
        pick = pick_from_rnd(rnd, last_lane_q);
        if (trail_q != '0) begin
            pick.lane = last_lane_q;
            pick.kind = COIN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trail_q <= '0;
        end else begin
            trail_q <= trail_d;
        end
    end
`else
    localparam int unused_trail_cfg = TRAIL_LEN + TRAIL_GAP;

    assign gap_value = gap_base;
    assign pick      = pick_from_rnd(rnd, last_lane_q);
`endif

    spawn_gap_timer u_gap_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (cd_load),
        .value      (gap_value),
        .frame_tick (tick_en),
        .expire     (expire)
    );

    always_comb begin
        state_d = state_q;
        cd_load = 1'b0;
        pick_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    cd_load = 1'b1;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                if (!run) begin
                    state_d = IDLE;
                end else begin
                    pick_en = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (spawn_ready) begin
                    cd_load = 1'b1;
                    state_d = COUNT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            spawn_q     <= '0;
            last_lane_q <= 2'd0;
            count_q     <= '0;
        end else begin
            state_q <= state_d;
            if (pick_en) begin
                spawn_q     <= pick;
                last_lane_q <= pick.lane;
            end
            // A handshake counts even in the cycle run drops.
            if (handshake) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign spawn_lane  = spawn_q.lane;
    assign spawn_kind  = spawn_valid ? spawn_q.kind : NONE;
    assign spawn_count = count_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: directed scenarios followed by a
// randomized run compared against a frame-level behavioural model.
module tb_obstacle_spawner;

    localparam int MIN_GAP        = 20;
    localparam int GAP_RANGE_BITS = 5;
    localparam int COIN_THRESH    = 4;
    localparam int TRAIL_LEN      = 3;
    localparam int TRAIL_GAP      = 4;

    logic        clock = 1'b0;
    logic        reset, frame_tick, run, spawn_ready, spawn_valid;
    logic [15:0] rnd, spawn_count;
    logic [1:0]  spawn_lane, spawn_kind;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_count;

    always #5 clock = ~clock;

    obstacle_spawner #(
        .MIN_GAP        (MIN_GAP),
        .GAP_RANGE_BITS (GAP_RANGE_BITS),
        .COIN_THRESH    (COIN_THRESH),
        .TRAIL_LEN      (TRAIL_LEN),
        .TRAIL_GAP      (TRAIL_GAP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .run         (run),
        .rnd         (rnd),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_lane  (spawn_lane),
        .spawn_kind  (spawn_kind),
        .spawn_count (spawn_count)
    );

    // Starting in the counting phase, deliver 'ticks' frame ticks, then present
    // prnd during the pick cycle and arrive at the first cycle of the offer.
    task automatic run_to_offer(input int ticks, input logic [15:0] prnd, input logic rdy);
        for (int i = 1; i <= ticks; i++) begin
            frame_tick = 1'b1;
            rnd = 16'($urandom);
            @(negedge clock);
            frame_tick = 1'b0;
            checks++;
            if (spawn_valid !== 1'b0) begin
                failures++;
                $display("FAIL early_valid tick=%0d/%0d valid=%b required=0", i, ticks, spawn_valid);
            end
            if (i < ticks) @(negedge clock);
        end
        rnd = prnd;
        spawn_ready = rdy;
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        checks++;
        if (spawn_valid !== 1'b1) begin
            failures++;
            $display("FAIL valid_latency valid=%b required=1", spawn_valid);
        end
    endtask

    task automatic finish_hs(input logic [15:0] reload);
        spawn_ready = 1'b1;
        rnd = reload;
        @(negedge clock);
        spawn_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        checks++;
        if (spawn_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_after_hs valid=%b required=0", spawn_valid);
        end
        checks++;
        if (spawn_count !== exp_count) begin
            failures++;
            $display("FAIL count_after_hs count=%0d required=%0d", spawn_count, exp_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; frame_tick = 1'b0; spawn_ready = 1'b0; rnd = 16'h0;
        repeat (2) @(negedge clock);
        checks++;
        if ({spawn_valid, spawn_lane, spawn_kind, spawn_count} !== 21'd0) begin
            failures++;
            $display("FAIL reset_state valid=%b lane=%0d kind=%0d count=%0d required=all 0",
                     spawn_valid, spawn_lane, spawn_kind, spawn_count);
        end
        reset = 1'b0;
        exp_count = 16'd0;
    endtask

    // Cooldown 27 from rnd=7, then a stalled high obstacle in lane 2.
    task automatic test_first_spawn_stall();
        run = 1'b1;
        rnd = 16'h0007;
        @(negedge clock);
        run_to_offer(27, 16'h01A2, 1'b0);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (spawn_valid !== 1'b1 || spawn_lane !== 2'd2 || spawn_kind !== 2'd2) begin
                failures++;
                $display("FAIL stall_stable cycle=%0d valid=%b lane=%0d kind=%0d required=1/2/2",
                         c, spawn_valid, spawn_lane, spawn_kind);
            end
            rnd = 16'($urandom);
            frame_tick = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        frame_tick = 1'b0;
        checks++;
        if (spawn_count !== exp_count) begin
            failures++;
            $display("FAIL stall_count count=%0d required=%0d", spawn_count, exp_count);
        end
        finish_hs(16'h0003);
    endtask

    // rnd[1:0]=3 after lane 2 wraps to lane 0.
    task automatic test_lane_wrap();
        run_to_offer(23, 16'h00F3, 1'b1);
        checks++;
        if (spawn_lane !== 2'd0 || spawn_kind !== 2'd1) begin
            failures++;
            $display("FAIL lane_wrap lane=%0d kind=%0d required=0/1", spawn_lane, spawn_kind);
        end
        finish_hs(16'h001F);
    endtask

    task automatic test_coin();
        run_to_offer(51, 16'h0031, 1'b1);
        checks++;
        if (spawn_lane !== 2'd1 || spawn_kind !== 2'd3) begin
            failures++;
            $display("FAIL coin lane=%0d kind=%0d required=1/3", spawn_lane, spawn_kind);
        end
        finish_hs(16'h0000);
    endtask

    task automatic test_trail();
`ifdef COIN_TRAIL_EN
        for (int k = 0; k < TRAIL_LEN; k++) begin
            run_to_offer(TRAIL_GAP, 16'($urandom), 1'b1);
            checks++;
            if (spawn_lane !== 2'd1 || spawn_kind !== 2'd3) begin
                failures++;
                $display("FAIL trail_coin idx=%0d lane=%0d kind=%0d required=1/3", k, spawn_lane, spawn_kind);
            end
            finish_hs((k == TRAIL_LEN - 1) ? 16'h0005 : 16'($urandom));
        end
        run_to_offer(25, 16'h0150, 1'b1);
`else
        run_to_offer(20, 16'h0150, 1'b1);
`endif
        checks++;
        if (spawn_lane !== 2'd0 || spawn_kind !== 2'd2) begin
            failures++;
            $display("FAIL after_coin lane=%0d kind=%0d required=0/2", spawn_lane, spawn_kind);
        end
        finish_hs(16'h0000);
    endtask

    task automatic test_run_abort();
        run_to_offer(20, 16'h0052, 1'b0);
        checks++;
        if (spawn_lane !== 2'd2 || spawn_kind !== 2'd1) begin
            failures++;
            $display("FAIL abort_offer lane=%0d kind=%0d required=2/1", spawn_lane, spawn_kind);
        end
        run = 1'b0;
        @(negedge clock);
        checks++;
        if (spawn_valid !== 1'b0 || spawn_kind !== 2'd0 || spawn_count !== exp_count) begin
            failures++;
            $display("FAIL abort_withdraw valid=%b kind=%0d count=%0d required=0/0/%0d",
                     spawn_valid, spawn_kind, spawn_count, exp_count);
        end
        @(negedge clock);
        run = 1'b1;
        rnd = 16'h0001;
        @(negedge clock);
        run_to_offer(21, 16'h0140, 1'b1);
        checks++;
        if (spawn_lane !== 2'd0 || spawn_kind !== 2'd2) begin
            failures++;
            $display("FAIL abort_restart lane=%0d kind=%0d required=0/2", spawn_lane, spawn_kind);
        end
        finish_hs(16'h0000);
    endtask

    task automatic test_hs_with_abort();
        run_to_offer(20, 16'h0061, 1'b0);
        run = 1'b0;
        spawn_ready = 1'b1;
        @(negedge clock);
        exp_count = exp_count + 16'd1;
        checks++;
        if (spawn_valid !== 1'b0 || spawn_count !== exp_count) begin
            failures++;
            $display("FAIL hs_abort valid=%b count=%0d required=0/%0d", spawn_valid, spawn_count, exp_count);
        end
        spawn_ready = 1'b0;
        run = 1'b1;
        rnd = 16'h0002;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_offer();
        run_to_offer(22, 16'h0052, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_count = 16'd0;
        checks++;
        if (spawn_valid !== 1'b0 || spawn_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_offer valid=%b count=%0d required=0/0", spawn_valid, spawn_count);
        end
    endtask

    // Model tracks frames left, a pending pick and an outstanding offer.
    task automatic test_random();
        bit          m_idle = 1, m_pick = 0, m_off = 0, hs;
        int          m_ticks = 0, m_lane = 0, m_kind = 0, m_last = 0, m_trail = 0;
        logic [15:0] m_cnt = 16'd0;
        int          mask = (1 << GAP_RANGE_BITS) - 1;
        for (int cyc = 0; cyc < 4000 && failures < 30; cyc++) begin
            checks++;
            if (spawn_valid !== m_off) begin
                failures++;
                $display("FAIL rnd_valid cyc=%0d valid=%b required=%b", cyc, spawn_valid, m_off);
            end
            checks++;
            if (spawn_kind !== (m_off ? 2'(m_kind) : 2'd0)) begin
                failures++;
                $display("FAIL rnd_kind cyc=%0d kind=%0d required=%0d", cyc, spawn_kind, m_off ? m_kind : 0);
            end
            checks++;
            if (spawn_count !== m_cnt) begin
                failures++;
                $display("FAIL rnd_count cyc=%0d count=%0d required=%0d", cyc, spawn_count, m_cnt);
            end
            if (m_off) begin
                checks++;
                if (spawn_lane !== 2'(m_lane)) begin
                    failures++;
                    $display("FAIL rnd_lane cyc=%0d lane=%0d required=%0d", cyc, spawn_lane, m_lane);
                end
            end
            run = ($urandom_range(0, 499) != 0);
            spawn_ready = 1'($urandom_range(0, 1));
            frame_tick = ($urandom_range(0, 2) == 0);
            rnd = 16'($urandom);
            hs = m_off && spawn_ready;
            if (hs) m_cnt = m_cnt + 16'd1;
            if (!run) begin
                m_idle = 1; m_pick = 0; m_off = 0; m_trail = 0;
            end else if (m_idle) begin
                m_idle = 0;
                m_ticks = MIN_GAP + (int'(rnd) & mask);
            end else if (m_pick) begin
                m_pick = 0;
                m_off = 1;
                if (m_trail > 0) begin
                    m_lane = m_last;
                    m_kind = 3;
                end else begin
                    m_lane = (rnd[1:0] != 2'd3) ? int'(rnd[1:0]) : (m_last + 1) % 3;
                    m_kind = (int'(rnd[7:4]) < COIN_THRESH) ? 3 : (rnd[8] ? 2 : 1);
                end
                m_last = m_lane;
            end else if (m_off) begin
                if (hs) begin
                    m_off = 0;
`ifdef COIN_TRAIL_EN
                    if (m_trail > 0) m_trail = m_trail - 1;
                    else if (m_kind == 3) m_trail = TRAIL_LEN;
`endif
                    m_ticks = (m_trail > 0) ? TRAIL_GAP : MIN_GAP + (int'(rnd) & mask);
                end
            end else if (frame_tick) begin
                if (m_ticks <= 1) m_pick = 1;
                else m_ticks = m_ticks - 1;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn_stall();
        test_lane_wrap();
        test_coin();
        test_trail();
        test_run_abort();
        test_hs_with_abort();
        test_reset_mid_offer();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
